control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath strobes.
// Optional feature: define BRANCH_NEG_EN to decode opcode 8 (blt) as a branch on the negative flag.
module control_unit #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       negative,
    input  logic       mem_ready,
    output logic [2:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSrc,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_REX    = 4'd2,
        S_RWB    = 4'd3,
        S_IEX    = 4'd4,
        S_IWB    = 4'd5,
        S_MADDR  = 4'd6,
        S_MRD    = 4'd7,
        S_MWB    = 4'd8,
        S_MWR    = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] wait_cnt;
    logic       mem_state;
    logic       timeout;
    logic       branch_taken;

    assign state     = cur_state;
    assign mem_state = (cur_state == S_FETCH) || (cur_state == S_MRD) || (cur_state == S_MWR);
    assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_MAX);

`ifdef BRANCH_NEG_EN
    always_comb begin
        case (opcode)
            4'd6:    branch_taken = zero;
            4'd7:    branch_taken = ~zero;
            4'd8:    branch_taken = negative;
            default: branch_taken = 1'b0;
        endcase
    end
`else
    logic unused_negative;
    assign unused_negative = negative;

    always_comb begin
        case (opcode)
            4'd6:    branch_taken = zero;
            4'd7:    branch_taken = ~zero;
            default: branch_taken = 1'b0;
        endcase
    end
`endif

    // Counter restarts whenever a new state is entered (or on abort back to FETCH);
    // it only advances while a memory state holds waiting for mem_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_FETCH;
            wait_cnt  <= 4'd0;
        end else begin
            cur_state <= nxt_state;
            if ((nxt_state != cur_state) || timeout)
                wait_cnt <= 4'd0;
            else if (!mem_ready)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        ALUOp     = 3'b000;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        PCSrc     = 1'b0;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
        RegDst    = 1'b0;
        illegal   = 1'b0;
        mem_err   = 1'b0;

        case (cur_state)
            S_FETCH: begin
                if (timeout) begin
                    mem_err   = 1'b1;
                    nxt_state = S_FETCH;
                end else begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    if (mem_ready)
                        nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    4'd0, 4'd1: nxt_state = S_REX;
                    4'd2, 4'd3: nxt_state = S_IEX;
                    4'd4, 4'd5: nxt_state = S_MADDR;
                    4'd6, 4'd7: nxt_state = S_BR;
`ifdef BRANCH_NEG_EN
                    4'd8:       nxt_state = S_BR;
`endif
                    4'd9:       nxt_state = S_JMP;
                    default: begin
                        illegal   = 1'b1;
                        nxt_state = S_FETCH;
                    end
                endcase
            end
            S_REX: begin
                ALUSrcA   = 2'b10;
                ALUOp     = {2'b00, opcode[0]};
                nxt_state = S_RWB;
            end
            S_RWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_IEX: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                ALUOp     = {2'b00, opcode[0]};
                nxt_state = S_IWB;
            end
            S_IWB: begin
                RegWrite  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_MADDR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                nxt_state = (opcode == 4'd5) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                if (timeout) begin
                    mem_err   = 1'b1;
                    nxt_state = S_FETCH;
                end else begin
                    MemRead = 1'b1;
                    if (mem_ready)
                        nxt_state = S_MWB;
                end
            end
            S_MWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_MWR: begin
                if (timeout) begin
                    mem_err   = 1'b1;
                    nxt_state = S_FETCH;
                end else begin
                    MemWrite = 1'b1;
                    if (mem_ready)
                        nxt_state = S_FETCH;
                end
            end
            S_BR: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 3'b001;
                PCSrc     = 1'b1;
                PCWrite   = branch_taken;
                nxt_state = S_FETCH;
            end
            S_JMP: begin
                PCSrc     = 1'b1;
                PCWrite   = 1'b1;
                nxt_state = S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase

        // Reset silences every output combinationally so a pending write dies without a clock edge.
        if (!reset) begin
            nxt_state = S_FETCH;
            ALUOp     = 3'b000;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            PCSrc     = 1'b0;
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            MemtoReg  = 1'b0;
            RegDst    = 1'b0;
            illegal   = 1'b0;
            mem_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected traces built from instruction classes.
module tb_control_unit;

    localparam int WAIT_MAX = 15;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
    logic       negative;
    logic       mem_ready;
    logic [2:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       PCSrc, PCWrite, IRWrite, MemRead, MemWrite;
    logic       RegWrite, MemtoReg, RegDst, illegal, mem_err;
    logic [3:0] state;

    control_unit #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .negative(negative),
        .mem_ready(mem_ready), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {ALUOp, ALUSrcA, ALUSrcB, PCSrc, PCWrite, IRWrite, MemRead, MemWrite,
    //                RegWrite, MemtoReg, RegDst, illegal, mem_err}
    localparam logic [16:0] ERR  = 17'h001;
    localparam logic [16:0] ILL  = 17'h002;
    localparam logic [16:0] RDST = 17'h004;
    localparam logic [16:0] M2R  = 17'h008;
    localparam logic [16:0] RW   = 17'h010;
    localparam logic [16:0] MW   = 17'h020;
    localparam logic [16:0] MR   = 17'h040;
    localparam logic [16:0] IRW  = 17'h080;
    localparam logic [16:0] PCW  = 17'h100;
    localparam logic [16:0] PCS  = 17'h200;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic        mr;
    } step_t;

    step_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] actual;
    assign actual = {ALUOp, ALUSrcA, ALUSrcB, PCSrc, PCWrite, IRWrite, MemRead, MemWrite,
                     RegWrite, MemtoReg, RegDst, illegal, mem_err};

    function automatic logic [16:0] sel(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        return {op, a, b, 10'b0};
    endfunction

    task automatic push(input logic [3:0] st, input logic [16:0] ctl, input logic mr);
        q.push_back('{st, ctl, mr});
    endtask

    task automatic push_any(input logic [3:0] st, input logic [16:0] ctl);
        push(st, ctl, 1'($urandom_range(0, 1)));
    endtask

    // A memory phase waits n cycles; n beyond the limit aborts with a lone mem_err cycle.
    task automatic mem_phase(input logic [3:0] st, input logic [16:0] busy, input logic [16:0] done,
                             input int n, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < n && i < WAIT_MAX; i++) push(st, busy, 1'b0);
        if (n > WAIT_MAX) begin
            push(st, ERR, 1'b0);
            aborted = 1'b1;
        end else begin
            push(st, done, 1'b1);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] op);
`ifdef BRANCH_NEG_EN
        return op <= 4'd9;
`else
        return (op <= 4'd9) && (op != 4'd8);
`endif
    endfunction

    task automatic build(input logic [3:0] op, input logic z, input logic n, input int fw, input int mw);
        bit ab;
        bit taken;
        q.delete();
        mem_phase(4'd0, sel(3'd0, 2'd0, 2'd1) | MR, sel(3'd0, 2'd0, 2'd1) | MR | IRW | PCW, fw, ab);
        if (ab) return;
        if (!is_legal(op)) begin
            push_any(4'd1, sel(3'd0, 2'd0, 2'd3) | ILL);
            return;
        end
        push_any(4'd1, sel(3'd0, 2'd0, 2'd3));
        if (op <= 4'd1) begin
            push_any(4'd2, sel({2'b00, op[0]}, 2'd2, 2'd0));
            push_any(4'd3, RW | RDST);
        end else if (op <= 4'd3) begin
            push_any(4'd4, sel({2'b00, op[0]}, 2'd2, 2'd2));
            push_any(4'd5, RW);
        end else if (op == 4'd4) begin
            push_any(4'd6, sel(3'd0, 2'd2, 2'd2));
            mem_phase(4'd7, MR, MR, mw, ab);
            if (!ab) push_any(4'd8, RW | M2R);
        end else if (op == 4'd5) begin
            push_any(4'd6, sel(3'd0, 2'd2, 2'd2));
            mem_phase(4'd9, MW, MW, mw, ab);
        end else if (op <= 4'd8) begin
            taken = (op == 4'd6) ? z : (op == 4'd7) ? !z : n;
            push_any(4'd10, sel(3'd1, 2'd2, 2'd0) | PCS | (taken ? PCW : 17'h0));
        end else begin
            push_any(4'd11, PCS | PCW);
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic run(input string name, input logic [3:0] op, input logic z, input logic n, input int limit);
        int k = 0;
        while (q.size() > 0 && k < limit) begin
            step_t s;
            s = q.pop_front();
            opcode = op; zero = z; negative = n; mem_ready = s.mr;
            #1;
            n_checks++;
            if (state !== s.st) begin
                n_fail++;
                $display("FAIL %s step%0d state: got %0d want %0d", name, k, state, s.st);
            end
            n_checks++;
            if (actual !== s.ctl) begin
                n_fail++;
                $display("FAIL %s step%0d ctl: got %05h want %05h", name, k, actual, s.ctl);
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic instr(input string name, input logic [3:0] op, input logic z, input logic n,
                         input int fw, input int mw);
        build(op, z, n, fw, mw);
        run(name, op, z, n, 1000);
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; opcode = 4'd0; zero = 1'b0; negative = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++;
        if (actual !== 17'h0) begin n_fail++; $display("FAIL reset_outputs: got %05h want 00000", actual); end
        reset = 1'b1;
    endtask

    task automatic test_add();
        instr("add", 4'd0, 1'b0, 1'b0, 0, 0);
        instr("sub", 4'd1, 1'b1, 1'b0, 1, 0);
        instr("addi", 4'd2, 1'b0, 1'b1, 0, 0);
        instr("subi", 4'd3, 1'b0, 1'b0, 2, 0);
        instr("jmp", 4'd9, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_branch();
        instr("beq_t", 4'd6, 1'b1, 1'b0, 0, 0);
        instr("beq_n", 4'd6, 1'b0, 1'b1, 0, 0);
        instr("bne_t", 4'd7, 1'b0, 1'b0, 0, 0);
        instr("bne_n", 4'd7, 1'b1, 1'b0, 0, 0);
        instr("blt_neg", 4'd8, 1'b0, 1'b1, 0, 0);
        instr("blt_pos", 4'd8, 1'b0, 1'b0, 0, 0);
        instr("op15", 4'd15, 1'b1, 1'b1, 0, 0);
        instr("op10", 4'd10, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_memory();
        instr("lw_wait3", 4'd4, 1'b0, 1'b0, 0, 3);
        instr("sw_wait2", 4'd5, 1'b0, 1'b0, 0, 2);
        instr("lw_fast", 4'd4, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_timeouts();
        instr("fetch_to", 4'd0, 1'b0, 1'b0, WAIT_MAX + 1, 0);
        instr("fetch_edge", 4'd0, 1'b0, 1'b0, WAIT_MAX, 0);
        instr("lw_to", 4'd4, 1'b0, 1'b0, 0, WAIT_MAX + 1);
        instr("lw_edge", 4'd4, 1'b0, 1'b0, 0, WAIT_MAX);
        instr("sw_to", 4'd5, 1'b0, 1'b0, 1, WAIT_MAX + 1);
        instr("sw_edge", 4'd5, 1'b0, 1'b0, 0, WAIT_MAX);
    endtask

    task automatic test_reset_mid_mwr();
        build(4'd5, 1'b0, 1'b0, 0, 5);
        run("sw_pre", 4'd5, 1'b0, 1'b0, 3);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (MemWrite !== 1'b1 || state !== 4'd9) begin
            n_fail++;
            $display("FAIL mwr_before_reset: got MemWrite=%0b state=%0d want 1 9", MemWrite, state);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL async_memwrite: got %0b want 0", MemWrite); end
        n_checks++;
        if (state !== 4'd0 || actual !== 17'h0) begin
            n_fail++;
            $display("FAIL async_reset: got state=%0d ctl=%05h want 0 00000", state, actual);
        end
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (state !== 4'd0 || actual !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got state=%0d ctl=%05h want 0 00000", state, actual);
        end
        reset = 1'b1;
        instr("after_reset", 4'd1, 1'b0, 1'b0, 0, 0);
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 2);
        if (r < 8) return WAIT_MAX;
        if (r == 8) return WAIT_MAX + 1;
        return 0;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 50; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            instr($sformatf("rnd%0d_op%0d", i, op), op, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), pick_wait(), pick_wait());
        end
    endtask

    task automatic test_back_to_back();
        instr("b2b_lw", 4'd4, 1'b0, 1'b0, 0, 0);
        instr("b2b_sw", 4'd5, 1'b0, 1'b0, 0, 0);
        instr("b2b_beq", 4'd6, 1'b1, 1'b0, 0, 0);
        opcode = 4'd0; mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL end_in_fetch: got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_memory();
        test_timeouts();
        test_reset_mid_mwr();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
